fifo_flagged: RTL

Parametrised synchronous FIFO with programmable-threshold flags, occupancy count, error pulses and a selectable read mode. It buffers request/response words between the Lease Cache memory controller and its traffic generators and checkers in the test environment. It is the general replacement for the fixed 8x8 FIFO.

---
 rtl/fifo_flagged.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fifo_flagged.sv
// Parametrised synchronous FIFO with threshold flags, occupancy count, error pulses
// and a selectable registered / first-word-fall-through read port.
module fifo_flagged #(
  parameter int unsigned  WIDTH     = 8,
  parameter int unsigned  DEPTH     = 8,
  parameter int unsigned  AF_THRESH = DEPTH - 1,
  parameter int unsigned  AE_THRESH = 1,
  parameter bit           FWFT      = 1'b0,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] din_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [1:0]       rst_sync_q;
  logic             ready;
  logic             rd_acc, wr_acc;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, ovf_d, unf_q, unf_d;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Reset asserts asynchronously; accesses are held off until release has been synchronised.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) rst_sync_q <= '0;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign ready = rst_sync_q[1];

  always_comb begin
    rd_acc   = ready & rd_en_i & ~empty_q;
    wr_acc   = ready & wr_en_i & (~full_q | rd_acc);
    wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    ovf_d    = ready & wr_en_i & full_q & ~rd_acc;
    unf_d    = ready & rd_en_i & empty_q;
  end

  // Flags derive from the next count so they move on the same edge as count_o.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_CNT);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= AF_CNT);
      ae_q     <= (count_d <= AE_CNT);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din_i;
  end

  if (FWFT) begin : g_fwft
    assign dout_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign valid_o = ~empty_q;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem_q[rd_ptr_q];
      end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
